// File: rtl/dem_pn_sequencer.sv
// dem_pn_sequencer
//
// Front end of the DEM DAC switching tree. Takes quantizer samples over a
// valid/ready handshake, clamps them to the tree range and presents the
// clamped tree input plus the raw code to the top switching block. A Galois
// LFSR advances once per accepted sample; its low NUM_STAGES bits are
// broadcast as one pseudorandom steering bit per switching block.
//
// Optional feature macro: DEM_PN_CLIP_COUNT_EN adds an 8-bit saturating
// count of clipped samples on clip_count_o.
//
// Ports:
//   clk_i             clock, rising edge
//   reset_i           asynchronous active-low reset
//   enable_i          run request
//   seed_load_i       load seed_i into the LFSR (highest priority input)
//   seed_i            LFSR seed value
//   sample_valid_i    a sample is offered
//   sample_i          unsigned quantizer code
//   sample_ready_o    a sample can be accepted this cycle (combinational)
//   x_top_o           clamped tree input for the top switching block
//   quantized_value_o registered raw sample
//   pn_seq_o          bit k steers switching block k
//   out_valid_o       one-cycle strobe, new output set
//   clip_o            one-cycle strobe, accepted sample exceeded NUM_STAGES+1
//   clip_count_o      saturating clipped-sample count (DEM_PN_CLIP_COUNT_EN only)
//   lockup_o          sticky, a zero seed was rejected or the LFSR hit zero
//
// States:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | stopped, no samples accepted, outputs hold
//   ST_SEED | one cycle, load seed_i (or SEED if seed_i is zero)
//   ST_RUN  | accepting one sample per cycle while enabled

module dem_pn_sequencer #(
    parameter int                  WIDTH      = 4,
    parameter int                  NUM_STAGES = 7,
    parameter int                  LFSR_LEN   = 16,
    parameter logic [LFSR_LEN-1:0] TAPS       = 16'hB400,
    parameter logic [LFSR_LEN-1:0] SEED       = 16'hACE1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  enable_i,
    input  logic                  seed_load_i,
    input  logic [LFSR_LEN-1:0]   seed_i,
    input  logic                  sample_valid_i,
    input  logic [WIDTH-1:0]      sample_i,
    output logic                  sample_ready_o,
    output logic [WIDTH-1:0]      x_top_o,
    output logic [WIDTH-1:0]      quantized_value_o,
    output logic [NUM_STAGES-1:0] pn_seq_o,
    output logic                  out_valid_o,
    output logic                  clip_o,
`ifdef DEM_PN_CLIP_COUNT_EN
    output logic [7:0]            clip_count_o,
`endif
    output logic                  lockup_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEED = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Largest tree input: one unit element per switching block plus one.
    localparam logic [WIDTH-1:0] X_MAX = WIDTH'(NUM_STAGES + 1);

    state_t              state;
    logic [LFSR_LEN-1:0] lfsr;
    logic [LFSR_LEN-1:0] lfsr_next;
    logic                accept;
    logic                sample_clipped;

    assign sample_ready_o = (state == ST_RUN) && !seed_load_i && enable_i;
    assign accept         = sample_valid_i && sample_ready_o;
    assign sample_clipped = (sample_i > X_MAX);

    always_comb begin
        lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state             <= ST_IDLE;
            lfsr              <= SEED;
            x_top_o           <= '0;
            quantized_value_o <= '0;
            pn_seq_o          <= '0;
            out_valid_o       <= 1'b0;
            clip_o            <= 1'b0;
            lockup_o          <= 1'b0;
`ifdef DEM_PN_CLIP_COUNT_EN
            clip_count_o      <= 8'd0;
`endif
        end else begin
            out_valid_o <= 1'b0;
            clip_o      <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (seed_load_i)   state <= ST_SEED;
                    else if (enable_i) state <= ST_RUN;
                end
                ST_SEED: begin
                    // A zero seed would freeze the LFSR; substitute the default.
                    if (seed_i != '0) begin
                        lfsr     <= seed_i;
                        lockup_o <= 1'b0;
                    end else begin
                        lfsr     <= SEED;
                        lockup_o <= 1'b1;
                    end
                    if (seed_load_i)   state <= ST_SEED;
                    else if (enable_i) state <= ST_RUN;
                    else               state <= ST_IDLE;
                end
                ST_RUN: begin
                    if (seed_load_i)    state <= ST_SEED;
                    else if (!enable_i) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            if (accept) begin
                lfsr              <= lfsr_next;
                pn_seq_o          <= lfsr_next[NUM_STAGES-1:0];
                quantized_value_o <= sample_i;
                x_top_o           <= sample_clipped ? X_MAX : sample_i;
                clip_o            <= sample_clipped;
                out_valid_o       <= 1'b1;
            end

            // Recovery from a corrupted all-zero LFSR; overrides a step.
            if ((state == ST_RUN) && (lfsr == '0)) begin
                lfsr     <= SEED;
                lockup_o <= 1'b1;
            end

`ifdef DEM_PN_CLIP_COUNT_EN
            if (seed_load_i) begin
                clip_count_o <= 8'd0;
            end else if (accept && sample_clipped && (clip_count_o != 8'hFF)) begin
                clip_count_o <= clip_count_o + 8'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_dem_pn_sequencer.sv
module tb_dem_pn_sequencer;

    localparam logic [15:0] TAPS_V = 16'hB400;
    localparam logic [15:0] SEED_V = 16'hACE1;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        enable_i;
    logic        seed_load_i;
    logic [15:0] seed_i;
    logic        sample_valid_i;
    logic [3:0]  sample_i;
    logic        sample_ready_o;
    logic [3:0]  x_top_o;
    logic [3:0]  quantized_value_o;
    logic [6:0]  pn_seq_o;
    logic        out_valid_o;
    logic        clip_o;
    logic        lockup_o;
`ifdef DEM_PN_CLIP_COUNT_EN
    logic [7:0]  clip_count_o;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: mode 0 = idle, 1 = seeding, 2 = running
    int          m_mode;
    logic [15:0] m_lfsr;
    logic        m_lock;
    logic [3:0]  e_x, e_q;
    logic [6:0]  e_pn;
    logic        e_valid, e_clip;

    always #5 clk_i = ~clk_i;

    dem_pn_sequencer dut (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .enable_i          (enable_i),
        .seed_load_i       (seed_load_i),
        .seed_i            (seed_i),
        .sample_valid_i    (sample_valid_i),
        .sample_i          (sample_i),
        .sample_ready_o    (sample_ready_o),
        .x_top_o           (x_top_o),
        .quantized_value_o (quantized_value_o),
        .pn_seq_o          (pn_seq_o),
        .out_valid_o       (out_valid_o),
        .clip_o            (clip_o),
`ifdef DEM_PN_CLIP_COUNT_EN
        .clip_count_o      (clip_count_o),
`endif
        .lockup_o          (lockup_o)
    );

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? TAPS_V : 16'h0000);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_lfsr  = SEED_V;
        m_lock  = 1'b0;
        e_x     = '0;
        e_q     = '0;
        e_pn    = '0;
        e_valid = 1'b0;
        e_clip  = 1'b0;
    endtask

    task automatic check_outputs();
        chk("x_top", x_top_o, e_x);
        chk("quantized", quantized_value_o, e_q);
        chk("pn_seq", pn_seq_o, e_pn);
        chk("out_valid", out_valid_o, e_valid);
        chk("clip", clip_o, e_clip);
        chk("lockup", lockup_o, m_lock);
    endtask

    // Called at a falling edge; drives one cycle, checks ready, then the
    // registered outputs after the rising edge, and returns at the next falling edge.
    task automatic cyc(input logic en, input logic ld, input logic [15:0] sd,
                       input logic v, input logic [3:0] s);
        logic m_ready;
        enable_i       = en;
        seed_load_i    = ld;
        seed_i         = sd;
        sample_valid_i = v;
        sample_i       = s;
        #1;
        m_ready = (m_mode == 2) && !ld && en;
        chk("ready", sample_ready_o, m_ready);
        if (m_mode == 1) begin
            if (sd != 16'h0) begin
                m_lfsr = sd;
                m_lock = 1'b0;
            end else begin
                m_lfsr = SEED_V;
                m_lock = 1'b1;
            end
        end
        if (m_ready && v) begin
            m_lfsr  = lfsr_step(m_lfsr);
            e_pn    = m_lfsr[6:0];
            e_q     = s;
            e_x     = (s > 4'd8) ? 4'd8 : s;
            e_clip  = (s > 4'd8);
            e_valid = 1'b1;
        end else begin
            e_valid = 1'b0;
            e_clip  = 1'b0;
        end
        m_mode = ld ? 1 : (en ? 2 : 0);
        @(posedge clk_i);
        #1;
        check_outputs();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        reset_i = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("reset_ready", sample_ready_o, 1'b0);
        @(negedge clk_i);
        reset_i = 1'b1;
    endtask

    initial begin
        logic en_r, ld_r, v_r;
        logic [15:0] sd_r;
        logic [3:0]  s_r;
        reset_i = 1'b0; enable_i = 1'b0; seed_load_i = 1'b0;
        seed_i = 16'h0; sample_valid_i = 1'b0; sample_i = 4'h0;
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        do_reset();

        // First sample after reset
        cyc(1, 0, 0, 1, 4'd5);              // still IDLE: not accepted
        cyc(1, 0, 0, 1, 4'd5);              // first RUN cycle
        chk("first_pn_70", pn_seq_o, 7'h70);
        chk("first_x_5", x_top_o, 4'd5);
        chk("first_valid", out_valid_o, 1'b1);

        // Back-to-back 3 then 4 from a fresh seed
        do_reset();
        cyc(1, 0, 0, 0, 4'd0);
        cyc(1, 0, 0, 1, 4'd3);
        chk("b2b_pn_70", pn_seq_o, 7'h70);
        chk("b2b_q_3", quantized_value_o, 4'd3);
        cyc(1, 0, 0, 1, 4'd4);
        chk("b2b_pn_38", pn_seq_o, 7'h38);
        chk("b2b_q_4", quantized_value_o, 4'd4);

        // Clamp boundary: 8 passes, 9 and 12 clip
        cyc(1, 0, 0, 1, 4'd8);
        chk("eight_noclip", clip_o, 1'b0);
        cyc(1, 0, 0, 1, 4'd12);
        chk("clip_x_8", x_top_o, 4'd8);
        chk("clip_q_12", quantized_value_o, 4'd12);
        chk("clip_pulse", clip_o, 1'b1);
        cyc(1, 0, 0, 0, 4'd0);
        chk("clip_drop", clip_o, 1'b0);
        cyc(1, 0, 0, 1, 4'd9);

        // Zero seed with a colliding sample, then seed 1
        cyc(1, 1, 16'h0000, 1, 4'd7);
        chk("ld_no_valid", out_valid_o, 1'b0);
        cyc(1, 0, 16'h0000, 1, 4'd7);       // SEED cycle: no acceptance
        chk("zero_seed_lock", lockup_o, 1'b1);
        cyc(1, 0, 0, 1, 4'd5);
        chk("reseed_pn_70", pn_seq_o, 7'h70);
        cyc(1, 1, 16'h0001, 0, 4'd0);
        cyc(1, 0, 16'h0001, 0, 4'd0);
        chk("seed1_unlock", lockup_o, 1'b0);
        cyc(1, 0, 0, 1, 4'd2);
        chk("seed1_pn_00", pn_seq_o, 7'h00);

        // Enable drop: no acceptance, then IDLE
        cyc(0, 0, 0, 1, 4'd6);
        cyc(1, 0, 0, 1, 4'd6);
        cyc(1, 0, 0, 1, 4'd1);

        // Reset between acceptance and output cycle
        enable_i = 1'b1; seed_load_i = 1'b0; sample_valid_i = 1'b1; sample_i = 4'd6;
        #1;
        chk("pre_rst_ready", sample_ready_o, 1'b1);
        #1;
        reset_i = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk_i);
        #1;
        chk("rst_no_valid", out_valid_o, 1'b0);
        chk("rst_pn_zero", pn_seq_o, 7'h00);
        @(negedge clk_i);
        reset_i = 1'b1;
        cyc(1, 0, 0, 0, 4'd0);
        cyc(1, 0, 0, 1, 4'd5);
        chk("post_rst_pn_70", pn_seq_o, 7'h70);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            en_r = ($urandom_range(0, 9) != 0);
            ld_r = (m_mode != 1) && ($urandom_range(0, 19) == 0);
            sd_r = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            v_r  = ($urandom_range(0, 3) != 0);
            s_r  = 4'($urandom_range(0, 15));
            cyc(en_r, ld_r, sd_r, v_r, s_r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
